exp_arbiter: RTL
================

Name: exp_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one exp datapath instance between NUM_REQ requesters.
- Accepts per-requester operand requests and drives the exp unit's enable/num handshake.
- Captures exp_num on data_ready and returns it to the winning requester with a one-cycle response pulse.
- Sits between the softmax/activation front-ends and the single exp instance; includes a watchdog so a stalled exp unit cannot hang requesters.

Parameters:
- DATA_WIDTH, 16, operand/result width (signed fixed point).
- FIXED_PNT, 8, fractional bits (passed through; no arithmetic performed here).
- NUM_REQ, 4, number of requesters (2..16).
- GAP_CYCLES, 2, cycles exp_enable is held low between operations (min 1).
- READY_MASK, 2, RUN cycles during which exp_data_ready is ignored, because data_ready may still be high from the previous operation.
- TIMEOUT_CYCLES, 64, RUN cycles before abort.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  request level per requester; held with operand until its resp_valid.
- req_num  in  NUM_REQ*DATA_WIDTH  operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- grant  out  NUM_REQ  one-hot, registered; high from accept until response.
- resp_valid  out  NUM_REQ  one-cycle pulse to the served requester.
- resp_data  out  DATA_WIDTH  result, valid with resp_valid.
- resp_err  out  1  high with resp_valid when the operation timed out.
- busy  out  1  state != IDLE.
- exp_enable  out  1  to exp.enable.
- exp_num  out  DATA_WIDTH  to exp.num; registered operand.
- exp_result  in  DATA_WIDTH  from exp.exp_num.
- exp_data_ready  in  1  from exp.data_ready; level, may be sticky.

Behaviour:
- Reset (async, any state):
  - All outputs 0.
  - state=IDLE; RR pointer last=NUM_REQ-1; counters 0.
  - Reset mid-operation drops exp_enable immediately; no response is issued.
- States: IDLE, RUN, GAP.
- IDLE:
  - If any req bit is high, pick the winner as the first set bit searching from (last+1) mod NUM_REQ upward with wrap.
  - On that edge: latch req_num[winner] into op_reg, set grant[winner], set last=winner, go to RUN.
  - If req=0, stay in IDLE.
- RUN:
  - exp_enable=1 and exp_num=op_reg, both registered; first asserted in the cycle after acceptance.
  - run_cnt starts at 0 and increments each RUN cycle.
  - Completion: exp_data_ready=1 while run_cnt>=READY_MASK.
    - Next edge: resp_data<=exp_result, resp_valid[winner]<=1, resp_err<=0, exp_enable<=0, grant<=0, go to GAP.
  - Timeout: run_cnt==TIMEOUT_CYCLES-1 without completion.
    - Next edge: resp_data<=0, resp_err<=1, resp_valid pulse, exp_enable<=0, go to GAP.
  - Completion and timeout in the same cycle: completion wins.
- GAP:
  - exp_enable=0 for exactly GAP_CYCLES cycles, then IDLE.
  - Guarantees the exp unit sees an enable rising edge on the next operation.
- resp_valid and resp_err are single-cycle pulses; resp_data holds its value until the next response.
- Requester dropping req after grant: the operation still completes and resp_valid still pulses (requester ignores it). Dropping req before grant: it is simply not selected.
- Back-to-back: a requester re-asserting req is eligible only after all other pending requesters have been served (RR fairness).
- Minimum throughput period per operation: 1 (accept) + RUN length + GAP_CYCLES.
- No arithmetic on data; width/fixed point are pass-through.

Test Plan:
Bench uses the real exp instance (DATA_WIDTH=16, FIXED_PNT=8) plus a stub-exp variant with programmable latency.
1. Single request: req=0001, req_num[0]=0x0000 -> grant=0001 next cycle, exp_enable high, then resp_valid=0001 with resp_data≈0x0100 (±2 LSB), resp_err=0, exp_enable low for 2 cycles.
2. RR fairness: req=1111 held, operands 0x0100/0x0080/0xFF00/0x0000 -> grant order 0,1,2,3,0; results ≈0x02B8, 0x01A6, 0x005E, 0x0100.
3. Sticky ready: stub holds exp_data_ready=1 from the previous op; new op with latency 10 -> no completion before run_cnt=READY_MASK; response taken at stub ready, not at cycle 0 of RUN.
4. Timeout: stub never raises ready -> after 64 RUN cycles resp_valid pulses, resp_err=1, resp_data=0x0000, then GAP, then the next requester is served.
5. Reset mid-RUN: rst_n low at RUN cycle 5 -> exp_enable, grant, busy drop asynchronously, no resp_valid; after release, pending req is re-arbitrated starting from requester 0.
6. Requester withdraws after grant: req[2] drops at RUN cycle 3 -> resp_valid[2] still pulses; req[2] is not re-granted.

Source files
------------

// File: rtl/exp_arbiter.sv
// Round-robin arbiter that time-shares a single exp datapath between NUM_REQ requesters.
// Sequences the exp enable/num handshake, masks stale data_ready and aborts stalled operations.
module exp_arbiter #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned FIXED_PNT      = 8,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned READY_MASK     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_num,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_err,
    output logic                          busy,
    output logic                          exp_enable,
    output logic [DATA_WIDTH-1:0]         exp_num,
    input  logic [DATA_WIDTH-1:0]         exp_result,
    input  logic                          exp_data_ready
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned RUN_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    // Fixed-point format is carried through untouched; only sanity-check the configuration.
    if (FIXED_PNT >= DATA_WIDTH || NUM_REQ < 2 || NUM_REQ > 16 || GAP_CYCLES < 1) begin : g_bad_params
        $error("exp_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_last;
    logic [RUN_W-1:0]       r_run_cnt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [NUM_REQ-1:0]     r_grant;
    logic [NUM_REQ-1:0]     r_resp_valid;
    logic [DATA_WIDTH-1:0]  r_resp_data;
    logic                   r_resp_err;
    logic                   r_busy;
    logic                   r_exp_enable;
    logic [DATA_WIDTH-1:0]  r_exp_num;

    logic                   w_any;
    logic [IDX_W-1:0]       w_winner;
    logic [IDX_W:0]         w_cand;
    logic                   w_done;
    logic                   w_timeout;

    // Priority search from last+1 upward with wrap; the last assignment is the closest candidate.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_last;
        w_cand   = '0;
        for (int i = int'(NUM_REQ); i >= 1; i--) begin
            w_cand = (IDX_W+1)'(r_last) + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (req[w_cand[IDX_W-1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_cand[IDX_W-1:0];
            end
        end
    end

    // data_ready may still be high from the previous operation during the first RUN cycles.
    assign w_done    = exp_data_ready && (r_run_cnt >= RUN_W'(READY_MASK));
    assign w_timeout = (r_run_cnt == RUN_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last       <= IDX_W'(NUM_REQ - 1);
            r_run_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_grant      <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_exp_enable <= 1'b0;
            r_exp_num    <= '0;
        end else begin
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state      <= S_RUN;
                        r_busy       <= 1'b1;
                        r_last       <= w_winner;
                        r_grant      <= NUM_REQ'(1) << w_winner;
                        r_exp_num    <= req_num[w_winner*DATA_WIDTH +: DATA_WIDTH];
                        r_exp_enable <= 1'b1;
                        r_run_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (w_done) begin
                        r_resp_data  <= exp_result;
                        r_resp_valid <= r_grant;
                        r_grant      <= '0;
                        r_exp_enable <= 1'b0;
                        r_gap_cnt    <= '0;
                        r_state      <= S_GAP;
                    end else if (w_timeout) begin
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= r_grant;
                        r_grant      <= '0;
                        r_exp_enable <= 1'b0;
                        r_gap_cnt    <= '0;
                        r_state      <= S_GAP;
                    end else begin
                        r_run_cnt <= r_run_cnt + RUN_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_grant      <= '0;
                    r_exp_enable <= 1'b0;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;
    assign exp_enable = r_exp_enable;
    assign exp_num    = r_exp_num;

endmodule
